// File: rtl/ddr4_db_rd_burst_tx.sv
// ddr4_db_rd_burst_tx: cycle-accurate DDR4 read-burst transmitter (1 clk = 1 UI).
// Queued read requests become preamble / toggling-strobe data / postamble bursts.
// Optional feature macro: DDR4_DB_RD_SEAMLESS_EN chains a lat=0 queue head onto the
// last data beat of the current burst with no postamble, idle or preamble gap.
module ddr4_db_rd_burst_tx #(
  parameter int DQ_WIDTH     = 16,
  parameter int DQS_BITS     = 4,
  parameter int BURST_LEN    = 8,
  parameter int PREAMBLE_UI  = 2,
  parameter int POSTAMBLE_UI = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          ddr4_reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [BURST_LEN*DQ_WIDTH-1:0] req_data,
  input  logic [5:0]                    req_lat,
  output logic [DQ_WIDTH-1:0]           dq_out,
  output logic                          dq_oe,
  output logic [DQS_BITS-1:0]           dqs_t_out,
  output logic [DQS_BITS-1:0]           dqs_c_out,
  output logic                          dqs_oe,
  output logic                          busy,
  output logic                          burst_done
);

  localparam int BW    = BURST_LEN * DQ_WIDTH;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW  = PW + 1;
  localparam int MAXP  = (BURST_LEN > PREAMBLE_UI) ?
                         ((BURST_LEN > POSTAMBLE_UI) ? BURST_LEN : POSTAMBLE_UI) :
                         ((PREAMBLE_UI > POSTAMBLE_UI) ? PREAMBLE_UI : POSTAMBLE_UI);
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PRE,
    ST_DATA,
    ST_POST
  } state_t;

  // Request queue storage and bookkeeping
  logic [BW-1:0]   data_mem_q [FIFO_DEPTH];
  logic [5:0]      lat_mem_q  [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            req_ready_q;
  logic            push, pop;
  logic [BW-1:0]   head_data;
  logic [5:0]      head_lat;

  // Burst engine state and registered pin drivers
  state_t               state_q;
  logic [5:0]           lat_cnt_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        shreg_q;
  logic [DQ_WIDTH-1:0]  dq_q;
  logic                 dq_oe_q;
  logic [DQS_BITS-1:0]  dqs_t_q;
  logic                 dqs_oe_q;
  logic                 burst_done_q;

  assign push      = req_valid && req_ready_q;
  assign head_data = data_mem_q[rptr_q];
  assign head_lat  = lat_mem_q[rptr_q];

  // Pop the queue head whenever the engine can take a new burst
  always_comb begin
    pop = 1'b0;
    if (count_q != '0) begin
      if (state_q == ST_IDLE) begin
        pop = 1'b1;
      end
`ifdef DDR4_DB_RD_SEAMLESS_EN
      else if ((state_q == ST_DATA) && (cnt_q == CW'(BURST_LEN - 1)) && (head_lat == 6'd0)) begin
        pop = 1'b1;
      end
`endif
    end
  end

  // Next occupancy; the pop is taken into account before deciding the next ready
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNTW'(1);
    end
  end

  // Payload storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wptr_q] <= req_data;
      lat_mem_q[wptr_q]  <= req_lat;
    end
  end

  // Queue pointers, occupancy and the registered ready flag
  always_ff @(posedge clk or negedge ddr4_reset_n) begin
    if (!ddr4_reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q     <= count_d;
      req_ready_q <= (count_d != CNTW'(FIFO_DEPTH));
    end
  end

  // Burst FSM; pin values are registered from the state of the previous cycle
  always_ff @(posedge clk or negedge ddr4_reset_n) begin
    if (!ddr4_reset_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dq_q         <= '0;
      dq_oe_q      <= 1'b0;
      dqs_t_q      <= '0;
      dqs_oe_q     <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      dq_q         <= '0;
      dq_oe_q      <= 1'b0;
      dqs_t_q      <= '0;
      dqs_oe_q     <= 1'b0;
      burst_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shreg_q   <= head_data;
            lat_cnt_q <= head_lat;
            cnt_q     <= '0;
            state_q   <= (head_lat != 6'd0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q == 6'd1) begin
            lat_cnt_q <= '0;
            cnt_q     <= '0;
            state_q   <= ST_PRE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 6'd1;
          end
        end
        ST_PRE: begin
          dqs_oe_q <= 1'b1;
          if (cnt_q == CW'(PREAMBLE_UI - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          dq_oe_q      <= 1'b1;
          dqs_oe_q     <= 1'b1;
          dq_q         <= shreg_q[DQ_WIDTH-1:0];
          dqs_t_q      <= {DQS_BITS{~cnt_q[0]}};
          burst_done_q <= (cnt_q == CW'(BURST_LEN - 1));
          shreg_q      <= shreg_q >> DQ_WIDTH;
          if (cnt_q == CW'(BURST_LEN - 1)) begin
            cnt_q <= '0;
`ifdef DDR4_DB_RD_SEAMLESS_EN
            if (pop) begin
              shreg_q <= head_data;
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_POST;
            end
`else
            state_q <= ST_POST;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_POST: begin
          dqs_oe_q <= 1'b1;
          if (cnt_q == CW'(POSTAMBLE_UI - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign dq_out     = dq_q;
  assign dq_oe      = dq_oe_q;
  assign dqs_t_out  = dqs_t_q;
  assign dqs_c_out  = ~dqs_t_q;
  assign dqs_oe     = dqs_oe_q;
  assign burst_done = burst_done_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ddr4_db_rd_burst_tx.sv
// tb_ddr4_db_rd_burst_tx: directed table checks plus a randomized run compared
// cycle by cycle against a timeline model built from burst start times.
// Honours DDR4_DB_RD_SEAMLESS_EN in its expectations when the design is built with it.
module tb_ddr4_db_rd_burst_tx;

  localparam int DQW   = 16;
  localparam int DQSB  = 4;
  localparam int BL    = 8;
  localparam int PRE   = 2;
  localparam int POST  = 1;
  localparam int DEPTH = 4;
  localparam int MAXC  = 8192;
  localparam int MAXR  = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [BL*DQW-1:0]  req_data = '0;
  logic [5:0]         req_lat = '0;
  logic [DQW-1:0]     dq_out;
  logic               dq_oe;
  logic [DQSB-1:0]    dqs_t_out;
  logic [DQSB-1:0]    dqs_c_out;
  logic               dqs_oe;
  logic               busy;
  logic               burst_done;

  ddr4_db_rd_burst_tx #(
    .DQ_WIDTH(DQW), .DQS_BITS(DQSB), .BURST_LEN(BL),
    .PREAMBLE_UI(PRE), .POSTAMBLE_UI(POST), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .ddr4_reset_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_lat(req_lat), .dq_out(dq_out), .dq_oe(dq_oe),
    .dqs_t_out(dqs_t_out), .dqs_c_out(dqs_c_out), .dqs_oe(dqs_oe),
    .busy(busy), .burst_done(burst_done)
  );

  typedef struct packed {
    logic [DQW-1:0]  dq;
    logic            dqoe;
    logic            dqsoe;
    logic [DQSB-1:0] dqst;
    logic [DQSB-1:0] dqsc;
    logic            done;
    logic            bsy;
    logic            rdy;
  } obs_t;

  typedef struct {
    int   off;
    obs_t exp;
  } vec_t;

  int    vecs = 0;
  int    errs = 0;
  int    cyc = 0;
  obs_t  trace [MAXC];
  bit    modelOn = 0;
  int    accE [$];
  int    accL [$];
  logic [BL*DQW-1:0] accD [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input logic [DQW-1:0] dq, input logic dqoe, input logic dqsoe,
                              input logic [DQSB-1:0] dqst, input logic done,
                              input logic bsy, input logic rdy);
    obs_t o;
    o.dq = dq; o.dqoe = dqoe; o.dqsoe = dqsoe; o.dqst = dqst; o.dqsc = ~dqst;
    o.done = done; o.bsy = bsy; o.rdy = rdy;
    return o;
  endfunction

  function automatic obs_t sampleNow();
    obs_t o;
    o.dq = dq_out; o.dqoe = dq_oe; o.dqsoe = dqs_oe; o.dqst = dqs_t_out; o.dqsc = dqs_c_out;
    o.done = burst_done; o.bsy = busy; o.rdy = req_ready;
    return o;
  endfunction

  // Every negedge: record what the pins show after the preceding posedge
  always @(negedge clk) begin
    if (cyc < MAXC) trace[cyc] = sampleNow();
  end

  task automatic checkOutput(input string name, input obs_t want);
    obs_t got;
    got = sampleNow();
    vecs++;
    if (got !== want) begin
      errs++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic checkVal(input string name, input int got, input int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Called on a negedge; returns on the negedge right after the accepting posedge
  task automatic applyStimulus(input logic [BL*DQW-1:0] d, input logic [5:0] lat,
                               output int acceptEdge);
    bit ok;
    ok = 0;
    acceptEdge = -1;
    req_data  = d;
    req_lat   = lat;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin
        acceptEdge = cyc + 1;
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!ok) begin
      vecs++;
      errs++;
      $display("[TB] FAIL accept_timeout got=0 want=1");
    end else if (modelOn) begin
      accE.push_back(acceptEdge);
      accL.push_back(int'(lat));
      accD.push_back(d);
    end
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy && !dqs_oe && !dq_oe) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("[TB] FAIL %s_drain_timeout got=busy want=idle", name);
    end
  endtask

  // Timeline model: derive each burst's pop edge P and first-beat edge B, then paint
  // preamble/postamble, overlay data beats, and derive occupancy, ready and busy
  task automatic modelCheck(input int rel, input int endC);
    int   n;
    int   P [MAXR];
    int   B [MAXR];
    bit   seam [MAXR];
    int   freeE;
    int   occ;
    bit   act;
    obs_t expv [MAXC];
    n = accE.size();
    if (n > MAXR || endC >= MAXC) begin
      vecs++;
      errs++;
      $display("[TB] FAIL model_capacity got=%0d want<=%0d", n, MAXR);
      return;
    end
    freeE = rel;
    for (int i = 0; i < n; i++) begin
      seam[i] = 0;
`ifdef DDR4_DB_RD_SEAMLESS_EN
      if (i > 0 && accL[i] == 0 && accE[i] <= B[i-1] + BL - 2) seam[i] = 1;
`endif
      if (seam[i]) begin
        P[i] = B[i-1] + BL - 1;
        B[i] = P[i] + 1;
      end else begin
        P[i] = (accE[i] + 1 > freeE) ? accE[i] + 1 : freeE;
        B[i] = P[i] + 1 + accL[i] + PRE;
      end
      freeE = B[i] + BL + POST;
    end
    for (int t = rel; t <= endC; t++) expv[t] = mk('0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      if (!seam[i])
        for (int t = B[i] - PRE; t < B[i]; t++) if (t >= rel && t <= endC) expv[t].dqsoe = 1'b1;
      for (int t = B[i] + BL; t < B[i] + BL + POST; t++)
        if (t >= rel && t <= endC) expv[t].dqsoe = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < BL; k++) begin
        int t;
        t = B[i] + k;
        if (t >= rel && t <= endC) begin
          expv[t].dq    = accD[i][k*DQW +: DQW];
          expv[t].dqoe  = 1'b1;
          expv[t].dqsoe = 1'b1;
          expv[t].dqst  = (k % 2 == 0) ? '1 : '0;
          expv[t].done  = (k == BL - 1);
        end
      end
    end
    for (int t = rel; t <= endC; t++) begin
      occ = 0;
      act = 0;
      for (int i = 0; i < n; i++) begin
        if (accE[i] <= t) occ++;
        if (P[i] <= t) occ--;
        if (P[i] <= t && t <= B[i] + BL + POST - 2) act = 1;
      end
      expv[t].dqsc = ~expv[t].dqst;
      expv[t].bsy  = (occ > 0) || act;
      expv[t].rdy  = (occ < DEPTH);
      vecs++;
      if (trace[t] !== expv[t]) begin
        errs++;
        $display("[TB] FAIL model_edge%0d got=%h want=%h", t, trace[t], expv[t]);
      end
    end
  endtask

  initial begin
    vec_t             tbl [14];
    logic [BL*DQW-1:0] d;
    logic [BL*DQW-1:0] d2;
    int               a, a2, ae, rel, endC;
    int               firstH, lastH, onCnt, dqsLow, gapExp, dqsLowExp, s2, hits;
    logic [5:0]       lat;

    // Single-burst pattern relative to the accept edge (offset 0)
    tbl[0]  = '{0,  mk('0, 0, 0, '0, 0, 1, 1)};
    tbl[1]  = '{1,  mk('0, 0, 0, '0, 0, 1, 1)};
    tbl[2]  = '{2,  mk('0, 0, 1, '0, 0, 1, 1)};
    tbl[3]  = '{3,  mk('0, 0, 1, '0, 0, 1, 1)};
    for (int k = 0; k < BL; k++)
      tbl[4+k] = '{4 + k, mk(16'(16'h1111 * (k + 1)), 1, 1, (k % 2 == 0) ? 4'hF : 4'h0,
                            k == BL - 1, 1, 1)};
    tbl[12] = '{12, mk('0, 0, 1, '0, 0, 0, 1)};
    tbl[13] = '{13, mk('0, 0, 0, '0, 0, 0, 1)};

    repeat (3) @(negedge clk);
    checkOutput("reset_state", mk('0, 0, 0, '0, 0, 0, 0));
    rst_n = 1'b1;
    checkOutput("release_before_edge", mk('0, 0, 0, '0, 0, 0, 0));
    @(negedge clk);
    checkOutput("ready_after_release", mk('0, 0, 0, '0, 0, 0, 1));
    repeat (5) @(negedge clk);

    // Single bursts with req_lat 0 and 5
    for (int k = 0; k < BL; k++) d[k*DQW +: DQW] = 16'(16'h1111 * (k + 1));
    for (int li = 0; li < 2; li++) begin
      int L;
      L = (li == 0) ? 0 : 5;
      applyStimulus(d, 6'(L), a);
      for (int o = 0; o < 14 + L; o++) begin
        int idx;
        idx = (o < L) ? 0 : o - L;
        checkOutput($sformatf("single_lat%0d_off%0d", L, tbl[idx].off + ((o < L) ? o : L)),
                    tbl[idx].exp);
        @(negedge clk);
      end
    end

    // Queue fill while a burst is active, then hold off a 5th request
    applyStimulus(d, 6'd0, a);
    for (int i = 0; i < DEPTH; i++) applyStimulus(d, 6'd0, ae);
    checkVal("ready_low_when_full", int'(req_ready), 0);
    applyStimulus(d, 6'd0, ae);
    checkVal("held_request_accept_edge", ae - a, 14);
    waitIdle("fill");

    // Two lat=0 requests back to back: gap 4 UI, or 0 with seamless chaining
    for (int k = 0; k < BL; k++) begin
      d[k*DQW +: DQW]  = 16'(k);
      d2[k*DQW +: DQW] = 16'(k + BL);
    end
    applyStimulus(d, 6'd0, a);
    applyStimulus(d2, 6'd0, a2);
    while (cyc < a + 38) @(negedge clk);
`ifdef DDR4_DB_RD_SEAMLESS_EN
    gapExp = 0; dqsLowExp = 0;
`else
    gapExp = 4; dqsLowExp = 1;
`endif
    firstH = -1; lastH = -1; onCnt = 0;
    for (int t = a; t < a + 36; t++) begin
      if (trace[t].dqoe) begin
        if (firstH < 0) firstH = t;
        lastH = t;
        onCnt++;
      end
    end
    dqsLow = 0;
    if (firstH >= 0)
      for (int t = firstH; t <= lastH; t++) if (!trace[t].dqsoe) dqsLow++;
    checkVal("b2b_first_beat_edge", firstH - a, 4);
    checkVal("b2b_beats_driven", onCnt, 2 * BL);
    checkVal("b2b_gap_ui", lastH - firstH + 1 - onCnt, gapExp);
    checkVal("b2b_dqs_oe_low_ui", dqsLow, dqsLowExp);
    s2 = firstH + BL + gapExp;
    if (s2 < 0) s2 = 0;
    checkVal("b2b_second_beat0", int'(trace[s2].dq), BL);
    checkVal("b2b_second_dqs_t", int'(trace[s2].dqst), 15);
    checkVal("b2b_first_last_dqs_t", int'(trace[s2 - gapExp - 1].dqst), 0);
    waitIdle("b2b");

    // Asynchronous reset at beat 3 with another request still queued
    applyStimulus(d, 6'd0, a);
    applyStimulus(d2, 6'd0, a2);
    while (cyc < a + 7) @(negedge clk);
    checkVal("beat3_before_reset", int'(dq_out), 3);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_midburst", mk('0, 0, 0, '0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_released", mk('0, 0, 0, '0, 0, 0, 0));
    @(negedge clk);
    checkOutput("queue_empty_after_reset", mk('0, 0, 0, '0, 0, 0, 1));
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (dqs_oe || dq_oe || busy) hits++;
      @(negedge clk);
    end
    checkVal("no_resume_after_reset", hits, 0);

    // Model-checked segment: queue wrap with 10 sequential requests, then random traffic
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc + 1;
    modelOn = 1;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < BL; k++) d[k*DQW +: DQW] = {8'(i + 1), 8'(k)};
      applyStimulus(d, 6'(i % 3), ae);
    end
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      lat = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 6)) : 6'd0;
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(d, lat, ae);
    end
    waitIdle("random");
    repeat (3) @(negedge clk);
    endC = cyc - 1;
    modelOn = 0;
    modelCheck(rel, endC);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
